keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner for the CHIP-8 core; successor to the fixed 4x4 scanner. Drives one column at a time for a configurable dwell, samples the rows at the end of each dwell, and debounces every key independently. It exposes a debounced key bitmap and, optionally, a valid/ready key-event stream, which the CPU uses for `FX0A`-style wait-for-key.

## Interface
- `COLS`, 4, number of matrix columns driven (≥2)
- `ROWS`, 4, number of matrix rows sampled (≥1)
- `SCAN_DIV`, 1000, clock cycles each column is driven (≥2)
- `DEBOUNCE`, 4, consecutive disagreeing samples needed to flip a key (≥1)
- `clk`  input  1  system clock; all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `column`  output  COLS  one-hot column drive, registered
- `row`  input  ROWS  row sense, 1 = key closed in the driven column
- `value`  output  ROWS*COLS  debounced key state; bit `r*COLS+c` = key at row r, column c
- `evt_valid`  output  1  key event pending
- `evt_ready`  input  1  consumer accepts event
- `evt_key`  output  clog2(ROWS*COLS)  index of reported key
- `evt_pressed`  output  1  1 = key now down, 0 = key now up

## Operation
- Column index `col` counts 0..COLS-1, then wraps to 0. Dwell counter `div` counts 0..SCAN_DIV-1, then wraps to 0. `col` advances on the `div` wrap.
- `column` = one-hot of `col`. It changes on the same edge as `col`.
- Sample point: the cycle with `div == SCAN_DIV-1`. `row` is sampled there, giving the rows maximum settling time.
- Per-key debounce counter `cnt[k]` is clog2(DEBOUNCE+1) bits wide. At each sample, for `k = r*COLS+col`:
  - If `row[r] == value[k]`, then `cnt[k] <= 0`.
  - Otherwise `cnt[k]` increments. When it would reach DEBOUNCE, `value[k]` toggles and `cnt[k] <= 0`.
- Keys outside the sampled column are untouched.
- Event logic uses a `pending` bitmap of ROWS*COLS bits:
  - `pending[k]` is set on the edge where `value[k]` toggles.
  - `evt_valid = |pending`.
  - `evt_key` = lowest set index.
  - `evt_pressed = value[evt_key]`.
- Accept happens when `evt_valid && evt_ready`. On accept, `pending[evt_key]` clears.
- Simultaneous accept and a new toggle of the same key: set wins. The key is reported again with its new state.
- Coalescing: a key that toggles twice before it is accepted gives one event carrying its current state. No events are ever dropped. Each key has at most one outstanding event.
- `evt_key` and `evt_pressed` may change while `evt_ready` is low, either because a lower index becomes pending or because of a re-toggle. Consumers sample only on accept.

## Timing
- Reset values:
  - `column = 1` (column 0 driven)
  - `col = 0`, `div = 0`
  - `value = 0`
  - all `cnt = 0`
  - `pending = 0`, `evt_valid = 0`
  - `evt_key = 0`, `evt_pressed = 0`
- Reset mid-scan aborts the dwell and clears all debounce progress and pending events. Scanning restarts at column 0 on the first cycle after reset deasserts.
- Full scan period = COLS*SCAN_DIV cycles. Each key is sampled once per period.
- `value[k]` toggles on the edge ending its DEBOUNCE-th consecutive disagreeing sample cycle. It is visible the next cycle. Minimum press latency is (DEBOUNCE-1)*COLS*SCAN_DIV+1 cycles after the first sample.
- `evt_valid` rises in the same cycle that `value[k]` shows the new state.
- `evt_valid`, `evt_key` and `evt_pressed` are combinational from registers. There is no combinational path from `evt_ready`.
- After an accept, the next pending key is presented in the following cycle.

## Configuration
- `KEYPAD_EVENT_EN` defined: `pending` bitmap, priority encoder and event handshake are built as above.
- Not defined: no `pending` logic.
  - `evt_valid`, `evt_key` and `evt_pressed` are tied to 0.
  - `evt_ready` is ignored.
  - `value` behaviour is identical.

## Structure
- Package `keypad_pkg` holds:
  - the `KEY_IDX_W(rows, cols)` width function
  - the default `COLS`, `ROWS`, `SCAN_DIV` and `DEBOUNCE` constants
  - the `key_evt_t` struct {key, pressed}
- Sub-module `keypad_prio_enc`: parametrised lowest-set-bit encoder (N-bit in, index + any out). It is used only under `KEYPAD_EVENT_EN`.
- Debounce counters are an inline generate array in the top module.

## Test plan
All scenarios use COLS=4, ROWS=4, SCAN_DIV=4, DEBOUNCE=2.
1. Reset, then free run.
   - Required: `column` goes 0001→0010→0100→1000→0001, 4 cycles each.
   - Required: `value=0`, `evt_valid=0`.
2. Hold `row[2]` high only while column 1 is driven, for ≥2 scans.
   - Required: `value[9]=1` after the 2nd sample.
   - Required: `evt_valid=1`, `evt_key=9`, `evt_pressed=1`.
   - Accept with `evt_ready=1`: `evt_valid=0` the next cycle.
3. Bounce: key 9 closed for one sample, then open.
   - Required: `value` stays 0, `cnt` clears, no event.
4. Keys 3 and 12 both stable down, `evt_ready=0`.
   - Required: `evt_key=3` held.
   - Raise `evt_ready` for 1 cycle: `evt_key=12`. After the second accept, `evt_valid=0`.
5. Key 5 pressed then released with `evt_ready=0` throughout.
   - Required: a single pending event, `evt_key=5`, `evt_pressed=0`.
6. Assert `reset` mid-debounce of key 0, one sample in.
   - Required: all outputs return to reset values.
   - Required: the next single sample does not set `value[0]`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the CHIP-8 matrix-keypad scanner: default geometry
// and timing, the key-index width function and the key-event record.
package keypad_pkg;

  localparam int DEF_COLS     = 4;
  localparam int DEF_ROWS     = 4;
  localparam int DEF_SCAN_DIV = 1000;
  localparam int DEF_DEBOUNCE = 4;

  // Widest key index the event record can carry (up to 65536 keys).
  localparam int KEY_W_MAX = 16;

  // Bits needed to name one key of a rows x cols matrix (never less than 1).
  function automatic int KEY_IDX_W(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // One key event: which key changed and whether it is now held down.
  typedef struct packed {
    logic [KEY_W_MAX-1:0] key;
    logic                 pressed;
  } key_evt_t;

endpackage

// File: rtl/keypad_prio_enc.sv
// Lowest-set-bit priority encoder. Reports the index of the lowest request
// bit and whether any bit is set; idx is 0 when no request is present.
module keypad_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix-keypad scanner. Drives one column at a time for
// SCAN_DIV cycles, samples the rows on the last cycle of each dwell and
// debounces every key independently. The key-event stream (pending bitmap,
// priority encoder, valid/ready handshake) is built only when the macro
// KEYPAD_EVENT_EN is defined; otherwise the event outputs are tied to 0.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  localparam int KEY_W   = KEY_IDX_W(ROWS, COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [COLS-1:0]      column,
  input  logic [ROWS-1:0]      row,
  output logic [ROWS*COLS-1:0] value,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEY_W-1:0]     evt_key,
  output logic                 evt_pressed
);

  localparam int NKEYS = ROWS * COLS;
  localparam int COL_W = $clog2(COLS);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [COL_W-1:0] col;
  logic [DIV_W-1:0] div;
  logic             sample;
  logic [NKEYS-1:0] toggle;

  // The last cycle of each dwell is the sample point: rows have settled.
  assign sample = (div == DIV_W'(SCAN_DIV - 1));

  // Dwell counter, column index and the registered one-hot column drive.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    if (reset) begin
      div    <= '0;
      col    <= '0;
      column <= COLS'(1);
    end else if (sample) begin
      div    <= '0;
      col    <= (col == COL_W'(COLS - 1)) ? '0 : col + 1'b1;
      column <= {column[COLS-2:0], column[COLS-1]};
    end else begin
      div    <= div + 1'b1;
    end
  end

  // One debounce counter and one debounced state bit per key.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = r * COLS + c;

      logic             hit;
      logic             key_val;
      logic [CNT_W-1:0] cnt;

      // This key is examined only at the sample point of its own column.
      assign hit       = sample && (col == COL_W'(c));
      assign toggle[K] = hit && (row[r] != key_val) &&
                         (cnt == CNT_W'(DEBOUNCE - 1));
      assign value[K]  = key_val;

      // Count consecutive disagreeing samples; flip the key on the last one.
      always_ff @(posedge clk) begin
        // NOTE: the counters are reset along with the state bit, because a
        // reset must discard any debounce progress made before it.
        if (reset) begin
          cnt     <= '0;
          key_val <= 1'b0;
        end else if (hit) begin
          if (row[r] == key_val) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            cnt     <= '0;
            key_val <= ~key_val;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef KEYPAD_EVENT_EN
  logic [NKEYS-1:0] pending;
  logic [NKEYS-1:0] clr_mask;
  logic [KEY_W-1:0] low_idx;
  logic             any;
  logic             accept;
  key_evt_t         evt;

  keypad_prio_enc #(
    .N (NKEYS),
    .W (KEY_W)
  ) u_prio_enc (
    .req (pending),
    .idx (low_idx),
    .any (any)
  );

  assign accept = any && evt_ready;

  // Clear mask for the key being accepted this cycle.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[low_idx] = 1'b1;
  end

  // One outstanding event per key; a fresh toggle beats a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | toggle;
  end

  // Present the lowest pending key together with its current state.
  always_comb begin
    evt                 = '0;
    evt.key[KEY_W-1:0]  = low_idx;
    evt.pressed         = value[low_idx];
  end

  assign evt_valid   = any;
  assign evt_key     = evt.key[KEY_W-1:0];
  assign evt_pressed = evt.pressed;
`else
  logic unused_evt;

  assign unused_evt  = ^{evt_ready, toggle};
  assign evt_valid   = 1'b0;
  assign evt_key     = '0;
  assign evt_pressed = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with COLS=4, ROWS=4, SCAN_DIV=4,
// DEBOUNCE=2. A physical keypad is modelled as a bitmap of closed keys; the
// row lines follow the column the DUT drives. Expected events are queued when
// a key is driven and compared when the bench accepts them.
module tb_keypad_scanner;

  localparam int COLS     = 4;
  localparam int ROWS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

`ifdef KEYPAD_EVENT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  column;
  logic [3:0]  row;
  logic [15:0] value;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_key;
  logic        evt_pressed;
  logic [15:0] keys = '0;

  keypad_scanner #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .column      (column),
    .row         (row),
    .value       (value),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_pressed (evt_pressed)
  );

  always #5 clk = ~clk;

  // A closed key connects its column line to its row line.
  always_comb begin
    row = '0;
    for (int r = 0; r < ROWS; r++) row[r] = |(column & keys[r*COLS +: COLS]);
  end

  typedef struct {
    int          scen;
    int          t;
    logic [15:0] keys;
    logic [15:0] exp_value;
    bit          exp_valid;
    logic [3:0]  exp_key;
    bit          exp_pressed;
    bit          acc;
    bit          push;
    logic [3:0]  pkey;
    bit          ppressed;
  } vec_t;

  typedef struct packed {
    logic [3:0] key;
    logic       pressed;
  } evt_t;

  vec_t vecs[$];
  evt_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cur_t    = 0;

  task automatic add(input int scen, input int t, input logic [15:0] k,
                     input logic [15:0] ev, input bit vv, input logic [3:0] vk,
                     input bit vp, input bit acc, input bit push,
                     input logic [3:0] pk, input bit pp);
    vec_t v;
    v.scen = scen; v.t = t; v.keys = k; v.exp_value = ev; v.exp_valid = vv;
    v.exp_key = vk; v.exp_pressed = vp; v.acc = acc; v.push = push;
    v.pkey = pk; v.ppressed = pp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cur_t++;
  endtask

  task automatic push_evt(input logic [3:0] k, input bit p);
    evt_t e;
    e.key = k;
    e.pressed = p;
    if (EVT_EN) sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " column"}, 32'(column), 32'h1);
    check({tag, " value"}, 32'(value), 32'h0);
    check({tag, " evt_valid"}, 32'(evt_valid), 32'h0);
    check({tag, " evt_key"}, 32'(evt_key), 32'h0);
    check({tag, " evt_pressed"}, 32'(evt_pressed), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    evt_ready = 1'b0;
    keys = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    sb.delete();
    reset = 1'b0;
    cur_t = 0;
  endtask

  // Compare outputs against the expected state at the current cycle.
  task automatic check_state(input string tag, input logic [15:0] ev,
                             input bit vv, input logic [3:0] vk, input bit vp);
    logic [3:0] exp_col;
    exp_col = 4'(1) << ((cur_t / SCAN_DIV) % COLS);
    check({tag, " column"}, 32'(column), 32'(exp_col));
    check({tag, " value"}, 32'(value), 32'(ev));
`ifdef KEYPAD_EVENT_EN
    check({tag, " evt_valid"}, 32'(evt_valid), 32'(vv));
    if (vv) begin
      check({tag, " evt_key"}, 32'(evt_key), 32'(vk));
      check({tag, " evt_pressed"}, 32'(evt_pressed), 32'(vp));
    end
`else
    check({tag, " evt_valid"}, 32'(evt_valid), 32'h0);
    check({tag, " evt_key"}, 32'(evt_key), 32'h0);
    check({tag, " evt_pressed"}, 32'(evt_pressed), 32'h0);
`endif
  endtask

  // Accept the presented event for one cycle and score it.
  task automatic accept(input string tag);
`ifdef KEYPAD_EVENT_EN
    evt_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s accept: event key %0d presented, none expected",
               tag, evt_key);
    end else begin
      e = sb.pop_front();
      check({tag, " sb key"}, 32'(evt_key), 32'(e.key));
      check({tag, " sb pressed"}, 32'(evt_pressed), 32'(e.pressed));
    end
`endif
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    prev;
    string tag;

    // scen, t, keys, value, valid, key, pressed, acc, push, pkey, ppressed
    // 1: free run, column rotation and idle outputs.
    add(1,  0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1,  3, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1,  4, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1,  8, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 12, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 15, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    // 2: key 9 (row 2, column 1) held; samples at t=7 and t=23.
    add(2,  0, 16'h0200, 16'h0000, 0, 0, 0, 0, 1, 9, 1);
    add(2, 23, 16'h0200, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(2, 24, 16'h0200, 16'h0200, 1, 9, 1, 1, 0, 0, 0);
    add(2, 25, 16'h0200, 16'h0200, 0, 0, 0, 0, 0, 0, 0);
    // 3: key 9 bounces for one sample, then a clean press from t=24.
    add(3,  0, 16'h0200, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(3,  8, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(3, 24, 16'h0200, 16'h0000, 0, 0, 0, 0, 1, 9, 1);
    add(3, 40, 16'h0200, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(3, 55, 16'h0200, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(3, 56, 16'h0200, 16'h0200, 1, 9, 1, 1, 0, 0, 0);
    add(3, 57, 16'h0200, 16'h0200, 0, 0, 0, 0, 0, 0, 0);
    // 4: keys 12 (t=20) and 3 (t=32); lowest index wins while not ready.
    add(4,  0, 16'h1008, 16'h0000, 0, 0, 0, 0, 1, 3, 1);
    add(4,  1, 16'h1008, 16'h0000, 0, 0, 0, 0, 1, 12, 1);
    add(4, 19, 16'h1008, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    add(4, 20, 16'h1008, 16'h1000, 1, 12, 1, 0, 0, 0, 0);
    add(4, 31, 16'h1008, 16'h1000, 1, 12, 1, 0, 0, 0, 0);
    add(4, 32, 16'h1008, 16'h1008, 1, 3, 1, 0, 0, 0, 0);
    add(4, 40, 16'h1008, 16'h1008, 1, 3, 1, 1, 0, 0, 0);
    add(4, 41, 16'h1008, 16'h1008, 1, 12, 1, 1, 0, 0, 0);
    add(4, 42, 16'h1008, 16'h1008, 0, 0, 0, 0, 0, 0, 0);
    // 5: key 5 pressed then released unaccepted: one coalesced release event.
    add(5,  0, 16'h0020, 16'h0000, 0, 0, 0, 0, 1, 5, 0);
    add(5, 24, 16'h0000, 16'h0020, 1, 5, 1, 0, 0, 0, 0);
    add(5, 55, 16'h0000, 16'h0020, 1, 5, 1, 0, 0, 0, 0);
    add(5, 56, 16'h0000, 16'h0000, 1, 5, 0, 1, 0, 0, 0);
    add(5, 57, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    // 6: key 1 pending, key 0 one sample in (t=35) when reset hits at t=37.
    add(6,  0, 16'h0002, 16'h0000, 0, 0, 0, 0, 1, 1, 1);
    add(6, 24, 16'h0001, 16'h0002, 1, 1, 1, 0, 0, 0, 0);
    add(6, 37, 16'h0001, 16'h0002, 1, 1, 1, 0, 0, 0, 0);

    prev = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].scen != prev) begin
        do_reset();
        prev = vecs[i].scen;
      end
      while (cur_t < vecs[i].t) tick();
      tag = $sformatf("s%0d t%0d", vecs[i].scen, cur_t);
      check_state(tag, vecs[i].exp_value, vecs[i].exp_valid,
                  vecs[i].exp_key, vecs[i].exp_pressed);
      keys = vecs[i].keys;
      if (vecs[i].push) push_evt(vecs[i].pkey, vecs[i].ppressed);
      if (vecs[i].acc) accept(tag);
    end

    // Reset mid-scan with a pending event and partial debounce of key 0.
    reset = 1'b1;
    tick();
    check_reset_state("mid reset");
    sb.delete();
    reset = 1'b0;
    cur_t = 0;
    keys = 16'h0001;
    push_evt(4'd0, 1'b1);
    while (cur_t < 4) tick();
    check_state("s6 after first sample", 16'h0000, 0, 0, 0);
    while (cur_t < 19) tick();
    check_state("s6 t19", 16'h0000, 0, 0, 0);
    tick();
    check_state("s6 t20", 16'h0001, 1, 0, 1);
    accept("s6 t20");
    check_state("s6 t21", 16'h0001, 0, 0, 0);
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
